// File: rtl/pong_pkg.sv
// Shared definitions for the two-player LED pong engine.
//   state_e   : engine FSM states
//   DEF_*     : default parameter values
//   score_w() : width of a score counter able to hold 0..win
package pong_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MOVE_R,
    S_MOVE_L,
    S_FLASH,
    S_OVER
  } state_e;

  localparam int unsigned DEF_N_LEDS      = 8;
  localparam int unsigned DEF_BASE_PERIOD = 25_000_000;
  localparam int unsigned DEF_SPEED_STEP  = 1_000_000;
  localparam int unsigned DEF_MIN_PERIOD  = 5_000_000;
  localparam int unsigned DEF_FLASH_HALF  = 12_500_000;
  localparam int unsigned DEF_FLASH_COUNT = 3;
  localparam int unsigned DEF_WIN_SCORE   = 7;

  function automatic int unsigned score_w(input int unsigned win);
    return (win < 1) ? 1 : $clog2(win + 1);
  endfunction

endpackage

// File: rtl/pong_tick_timer.sv
// Loadable down-counter shared by ball steps and flash phases.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load load_val (takes priority over counting)
//   load_val   : value loaded; expiry follows load_val+1 enabled cycles
//   en         : count enable
//   expire     : one-cycle pulse while enabled and the count is zero
module pong_tick_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expire
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)                    cnt_d = load_val;
    else if (en && cnt_q != '0)  cnt_d = cnt_q - 1'b1;
  end

  assign expire = en && (cnt_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/pong_engine.sv
// Two-player LED pong engine: ball FSM, hit latches, scores, rally count,
// speed-up on each return, miss flash and game-over display.
//   Clk, Rst          : clock, asynchronous active-low reset
//   serve_l/serve_r   : level serve buttons (rising edge used)
//   paddle_l/paddle_r : level paddle buttons (rising edge used)
//   leds              : registered LED bar
//   score_l/score_r   : player scores
//   rally             : returns in current rally, saturating at 255
//   server            : next server (0 left, 1 right)
//   game_over         : high in OVER
module pong_engine
  import pong_pkg::*;
#(
  parameter int unsigned N_LEDS      = DEF_N_LEDS,
  parameter int unsigned BASE_PERIOD = DEF_BASE_PERIOD,
  parameter int unsigned SPEED_STEP  = DEF_SPEED_STEP,
  parameter int unsigned MIN_PERIOD  = DEF_MIN_PERIOD,
  parameter int unsigned FLASH_HALF  = DEF_FLASH_HALF,
  parameter int unsigned FLASH_COUNT = DEF_FLASH_COUNT,
  parameter int unsigned WIN_SCORE   = DEF_WIN_SCORE,
  localparam int unsigned SCORE_W    = score_w(WIN_SCORE)
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               serve_l,
  input  logic               serve_r,
  input  logic               paddle_l,
  input  logic               paddle_r,
  output logic [N_LEDS-1:0]  leds,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic [7:0]         rally,
  output logic               server,
  output logic               game_over
);

  localparam int unsigned PW = $clog2(N_LEDS);
  localparam int unsigned TW = $clog2(((BASE_PERIOD > FLASH_HALF) ? BASE_PERIOD : FLASH_HALF) + 1);
  localparam int unsigned FW = (FLASH_COUNT > 1) ? $clog2(FLASH_COUNT) : 1;

  state_e             state_q, state_d;
  logic [PW-1:0]      pos_q, pos_d;
  logic               hit_l_q, hit_l_d, hit_r_q, hit_r_d;
  logic [SCORE_W-1:0] score_l_q, score_l_d, score_r_q, score_r_d;
  logic [7:0]         rally_q, rally_d;
  logic               server_q, server_d;
  logic [TW-1:0]      period_q, period_d;
  logic               flash_on_q, flash_on_d;
  logic [FW-1:0]      pair_q, pair_d;
  logic [N_LEDS-1:0]  leds_q, leds_d;
  logic               game_over_q, game_over_d;
  logic               sl_prev_q, sr_prev_q, pl_prev_q, pr_prev_q;

  logic               sl_e, sr_e, pl_e, pr_e;
  logic               hit_l_now, hit_r_now;
  logic               t_load, t_en, t_expire;
  logic [TW-1:0]      t_val, next_period;
  logic [N_LEDS-1:0]  low_mask;

  assign sl_e = serve_l  & ~sl_prev_q;
  assign sr_e = serve_r  & ~sr_prev_q;
  assign pl_e = paddle_l & ~pl_prev_q;
  assign pr_e = paddle_r & ~pr_prev_q;

  // A paddle edge coinciding with expiry still counts as a hit.
  assign hit_l_now = hit_l_q | (pl_e && state_q == S_MOVE_L && pos_q == '0);
  assign hit_r_now = hit_r_q | (pr_e && state_q == S_MOVE_R && pos_q == PW'(N_LEDS - 1));

  assign t_en = (state_q == S_MOVE_R) || (state_q == S_MOVE_L) || (state_q == S_FLASH);

  always_comb begin
    for (int unsigned i = 0; i < N_LEDS; i++) low_mask[i] = (i < N_LEDS / 2);
  end

  always_comb begin
    if (period_q >= TW'(MIN_PERIOD + SPEED_STEP)) next_period = period_q - TW'(SPEED_STEP);
    else                                          next_period = TW'(MIN_PERIOD);
  end

  always_comb begin
    state_d    = state_q;
    pos_d      = pos_q;
    hit_l_d    = hit_l_q;
    hit_r_d    = hit_r_q;
    score_l_d  = score_l_q;
    score_r_d  = score_r_q;
    rally_d    = rally_q;
    server_d   = server_q;
    period_d   = period_q;
    flash_on_d = flash_on_q;
    pair_d     = pair_q;
    t_load     = 1'b0;
    t_val      = period_q - 1'b1;

    case (state_q)
      S_IDLE: begin
        if ((!server_q && sl_e) || (server_q && sr_e)) begin
          state_d  = server_q ? S_MOVE_L : S_MOVE_R;
          pos_d    = server_q ? PW'(N_LEDS - 1) : '0;
          period_d = TW'(BASE_PERIOD);
          rally_d  = '0;
          hit_l_d  = 1'b0;
          hit_r_d  = 1'b0;
          t_load   = 1'b1;
          t_val    = TW'(BASE_PERIOD - 1);
        end
      end
      S_MOVE_R: begin
        hit_r_d = hit_r_now;
        if (t_expire) begin
          t_load = 1'b1;
          if (pos_q != PW'(N_LEDS - 1)) begin
            pos_d = pos_q + 1'b1;
          end else if (hit_r_now) begin
            state_d  = S_MOVE_L;
            pos_d    = PW'(N_LEDS - 2);
            rally_d  = (rally_q == 8'hFF) ? rally_q : rally_q + 1'b1;
            period_d = next_period;
            t_val    = next_period - 1'b1;
            hit_r_d  = 1'b0;
          end else begin
            state_d    = S_FLASH;
            score_l_d  = (score_l_q == SCORE_W'(WIN_SCORE)) ? score_l_q : score_l_q + 1'b1;
            server_d   = 1'b1;
            flash_on_d = 1'b1;
            pair_d     = '0;
            t_val      = TW'(FLASH_HALF - 1);
            hit_r_d    = 1'b0;
          end
        end
      end
      S_MOVE_L: begin
        hit_l_d = hit_l_now;
        if (t_expire) begin
          t_load = 1'b1;
          if (pos_q != '0) begin
            pos_d = pos_q - 1'b1;
          end else if (hit_l_now) begin
            state_d  = S_MOVE_R;
            pos_d    = PW'(1);
            rally_d  = (rally_q == 8'hFF) ? rally_q : rally_q + 1'b1;
            period_d = next_period;
            t_val    = next_period - 1'b1;
            hit_l_d  = 1'b0;
          end else begin
            state_d    = S_FLASH;
            score_r_d  = (score_r_q == SCORE_W'(WIN_SCORE)) ? score_r_q : score_r_q + 1'b1;
            server_d   = 1'b0;
            flash_on_d = 1'b1;
            pair_d     = '0;
            t_val      = TW'(FLASH_HALF - 1);
            hit_l_d    = 1'b0;
          end
        end
      end
      S_FLASH: begin
        if (t_expire) begin
          if (flash_on_q) begin
            flash_on_d = 1'b0;
            t_load     = 1'b1;
            t_val      = TW'(FLASH_HALF - 1);
          end else if (pair_q == FW'(FLASH_COUNT - 1)) begin
            state_d = (score_l_q == SCORE_W'(WIN_SCORE) || score_r_q == SCORE_W'(WIN_SCORE))
                      ? S_OVER : S_IDLE;
          end else begin
            pair_d     = pair_q + 1'b1;
            flash_on_d = 1'b1;
            t_load     = 1'b1;
            t_val      = TW'(FLASH_HALF - 1);
          end
        end
      end
      S_OVER: begin
        if (sl_e || sr_e) begin
          state_d   = S_IDLE;
          score_l_d = '0;
          score_r_d = '0;
          server_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // LEDs follow the next state so they stay aligned with the registered state.
    leds_d = '0;
    case (state_d)
      S_IDLE:             leds_d[server_d ? PW'(N_LEDS - 1) : PW'(0)] = 1'b1;
      S_MOVE_R, S_MOVE_L: leds_d[pos_d] = 1'b1;
      S_FLASH:            leds_d = flash_on_d ? '1 : '0;
      S_OVER:             leds_d = (score_l_d == SCORE_W'(WIN_SCORE)) ? low_mask : ~low_mask;
      default:            leds_d = '0;
    endcase
    game_over_d = (state_d == S_OVER);
  end

  pong_tick_timer #(.W(TW)) u_timer (
    .clk      (Clk),
    .rst_n    (Rst),
    .load     (t_load),
    .load_val (t_val),
    .en       (t_en),
    .expire   (t_expire)
  );

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q     <= S_IDLE;
      pos_q       <= '0;
      hit_l_q     <= 1'b0;
      hit_r_q     <= 1'b0;
      score_l_q   <= '0;
      score_r_q   <= '0;
      rally_q     <= '0;
      server_q    <= 1'b0;
      period_q    <= TW'(BASE_PERIOD);
      flash_on_q  <= 1'b0;
      pair_q      <= '0;
      leds_q      <= N_LEDS'(1);
      game_over_q <= 1'b0;
      sl_prev_q   <= 1'b0;
      sr_prev_q   <= 1'b0;
      pl_prev_q   <= 1'b0;
      pr_prev_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      hit_l_q     <= hit_l_d;
      hit_r_q     <= hit_r_d;
      score_l_q   <= score_l_d;
      score_r_q   <= score_r_d;
      rally_q     <= rally_d;
      server_q    <= server_d;
      period_q    <= period_d;
      flash_on_q  <= flash_on_d;
      pair_q      <= pair_d;
      leds_q      <= leds_d;
      game_over_q <= game_over_d;
      sl_prev_q   <= serve_l;
      sr_prev_q   <= serve_r;
      pl_prev_q   <= paddle_l;
      pr_prev_q   <= paddle_r;
    end
  end

  assign leds      = leds_q;
  assign score_l   = score_l_q;
  assign score_r   = score_r_q;
  assign rally     = rally_q;
  assign server    = server_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_pong_engine.sv
module tb_pong_engine;

  logic       Clk, Rst;
  logic       serve_l, serve_r, paddle_l, paddle_r;
  logic [7:0] leds;
  logic [1:0] score_l, score_r;
  logic [7:0] rally;
  logic       server, game_over;

  int checks = 0;
  int errors = 0;

  pong_engine #(
    .N_LEDS      (8),
    .BASE_PERIOD (4),
    .SPEED_STEP  (1),
    .MIN_PERIOD  (2),
    .FLASH_HALF  (2),
    .FLASH_COUNT (2),
    .WIN_SCORE   (2)
  ) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .serve_l   (serve_l),
    .serve_r   (serve_r),
    .paddle_l  (paddle_l),
    .paddle_r  (paddle_r),
    .leds      (leds),
    .score_l   (score_l),
    .score_r   (score_r),
    .rally     (rally),
    .server    (server),
    .game_over (game_over)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // t: negedge index after reset release; in = {serve_l, serve_r, paddle_l, paddle_r}
  // applied after the expected outputs at t are checked.
  typedef struct {
    int         t;
    logic [3:0] in;
    logic [7:0] leds;
    logic [1:0] scl;
    logic [1:0] scr;
    logic [7:0] rally;
    logic       srv;
    logic       go;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int t, input logic [3:0] in, input logic [7:0] l,
                     input logic [1:0] scl, input logic [1:0] scr,
                     input logic [7:0] ra, input logic srv, input logic go);
    vec_t v;
    v.t = t; v.in = in; v.leds = l; v.scl = scl; v.scr = scr;
    v.rally = ra; v.srv = srv; v.go = go;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_leds(input logic [7:0] target, input int budget, input string name);
    int n = 0;
    while (leds !== target && n < budget) begin
      @(negedge Clk);
      n++;
    end
    chk(name, {24'd0, leds}, {24'd0, target});
  endtask

  task automatic count_hold(output int n);
    logic [7:0] start;
    start = leds;
    n = 0;
    while (leds === start && n < 64) begin
      @(negedge Clk);
      n++;
    end
  endtask

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    int cur_t;
    int n;
    logic [7:0] end_led, next_led;

    Rst = 1'b0; serve_l = 1'b0; serve_r = 1'b0; paddle_l = 1'b0; paddle_r = 1'b0;

    // Scenarios 1-3 and 5 as one continuous directed run.
    add(  0, 4'b0100, 8'h01, 0, 0, 0, 0, 0);  // reset state; wrong-player serve
    add(  1, 4'b0000, 8'h01, 0, 0, 0, 0, 0);
    add(  2, 4'b1000, 8'h01, 0, 0, 0, 0, 0);  // left serves
    add(  3, 4'b0000, 8'h01, 0, 0, 0, 0, 0);
    add(  6, 4'b0000, 8'h01, 0, 0, 0, 0, 0);
    add(  7, 4'b0000, 8'h02, 0, 0, 0, 0, 0);
    add( 11, 4'b0000, 8'h04, 0, 0, 0, 0, 0);
    add( 30, 4'b0000, 8'h40, 0, 0, 0, 0, 0);
    add( 31, 4'b0001, 8'h80, 0, 0, 0, 0, 0);  // right paddle at far end
    add( 32, 4'b0000, 8'h80, 0, 0, 0, 0, 0);
    add( 34, 4'b0000, 8'h80, 0, 0, 0, 0, 0);
    add( 35, 4'b0000, 8'h40, 0, 0, 1, 0, 0);
    add( 37, 4'b0000, 8'h40, 0, 0, 1, 0, 0);
    add( 38, 4'b0000, 8'h20, 0, 0, 1, 0, 0);  // 3-cycle steps now
    add( 41, 4'b0000, 8'h10, 0, 0, 1, 0, 0);
    add( 52, 4'b0000, 8'h02, 0, 0, 1, 0, 0);
    add( 53, 4'b0010, 8'h01, 0, 0, 1, 0, 0);  // left paddle at far end
    add( 54, 4'b0000, 8'h01, 0, 0, 1, 0, 0);
    add( 55, 4'b0000, 8'h01, 0, 0, 1, 0, 0);
    add( 56, 4'b0000, 8'h02, 0, 0, 2, 0, 0);
    add( 57, 4'b0000, 8'h02, 0, 0, 2, 0, 0);
    add( 58, 4'b0000, 8'h04, 0, 0, 2, 0, 0);  // 2-cycle steps now
    add( 66, 4'b0001, 8'h40, 0, 0, 2, 0, 0);  // early paddle, ignored
    add( 67, 4'b0000, 8'h40, 0, 0, 2, 0, 0);
    add( 68, 4'b0000, 8'h80, 0, 0, 2, 0, 0);
    add( 69, 4'b0000, 8'h80, 0, 0, 2, 0, 0);
    add( 70, 4'b0000, 8'hFF, 1, 0, 2, 1, 0);  // miss: flash
    add( 71, 4'b0000, 8'hFF, 1, 0, 2, 1, 0);
    add( 72, 4'b0000, 8'h00, 1, 0, 2, 1, 0);
    add( 73, 4'b0000, 8'h00, 1, 0, 2, 1, 0);
    add( 74, 4'b0000, 8'hFF, 1, 0, 2, 1, 0);
    add( 75, 4'b0000, 8'hFF, 1, 0, 2, 1, 0);
    add( 76, 4'b0000, 8'h00, 1, 0, 2, 1, 0);
    add( 77, 4'b0000, 8'h00, 1, 0, 2, 1, 0);
    add( 78, 4'b0100, 8'h80, 1, 0, 2, 1, 0);  // IDLE at right end; right serves
    add( 79, 4'b0000, 8'h80, 1, 0, 0, 1, 0);
    add( 82, 4'b0000, 8'h80, 1, 0, 0, 1, 0);
    add( 83, 4'b0000, 8'h40, 1, 0, 0, 1, 0);
    add(106, 4'b0000, 8'h02, 1, 0, 0, 1, 0);
    add(107, 4'b0010, 8'h01, 1, 0, 0, 1, 0);  // left returns
    add(108, 4'b0000, 8'h01, 1, 0, 0, 1, 0);
    add(110, 4'b0000, 8'h01, 1, 0, 0, 1, 0);
    add(111, 4'b0000, 8'h02, 1, 0, 1, 1, 0);
    add(114, 4'b0000, 8'h04, 1, 0, 1, 1, 0);
    add(128, 4'b0000, 8'h40, 1, 0, 1, 1, 0);
    add(131, 4'b0000, 8'h80, 1, 0, 1, 1, 0);
    add(132, 4'b0000, 8'hFF, 2, 0, 1, 1, 0);  // winning miss
    add(139, 4'b0000, 8'h00, 2, 0, 1, 1, 0);
    add(140, 4'b0100, 8'h0F, 2, 0, 1, 1, 1);  // OVER, left won; serve_r clears
    add(141, 4'b0000, 8'h01, 0, 0, 1, 0, 0);

    repeat (3) @(negedge Clk);
    Rst = 1'b1;
    cur_t = 0;

    for (int i = 0; i < vecs.size(); i++) begin
      repeat (vecs[i].t - cur_t) @(negedge Clk);
      cur_t = vecs[i].t;
      chk($sformatf("leds@%0d", cur_t),      {24'd0, leds},      {24'd0, vecs[i].leds});
      chk($sformatf("score_l@%0d", cur_t),   {30'd0, score_l},   {30'd0, vecs[i].scl});
      chk($sformatf("score_r@%0d", cur_t),   {30'd0, score_r},   {30'd0, vecs[i].scr});
      chk($sformatf("rally@%0d", cur_t),     {24'd0, rally},     {24'd0, vecs[i].rally});
      chk($sformatf("server@%0d", cur_t),    {31'd0, server},    {31'd0, vecs[i].srv});
      chk($sformatf("game_over@%0d", cur_t), {31'd0, game_over}, {31'd0, vecs[i].go});
      {serve_l, serve_r, paddle_l, paddle_r} = vecs[i].in;
    end

    // Five returns: step period after each return must be 3,2,2,2,2.
    @(negedge Clk);
    serve_l = 1'b1;
    @(negedge Clk);
    serve_l = 1'b0;
    for (int r = 1; r <= 5; r++) begin
      end_led  = (r % 2 == 1) ? 8'h80 : 8'h01;
      next_led = (r % 2 == 1) ? 8'h40 : 8'h02;
      wait_leds(end_led, 64, $sformatf("reach_end_r%0d", r));
      if (r % 2 == 1) paddle_r = 1'b1; else paddle_l = 1'b1;
      @(negedge Clk);
      paddle_r = 1'b0;
      paddle_l = 1'b0;
      wait_leds(next_led, 16, $sformatf("return_move_r%0d", r));
      chk($sformatf("rally_r%0d", r), {24'd0, rally}, r);
      count_hold(n);
      chk($sformatf("period_r%0d", r), n, (4 - r > 2) ? 4 - r : 2);
    end

    // Asynchronous reset between clock edges, mid-rally.
    @(posedge Clk);
    #2;
    Rst = 1'b0;
    #1;
    chk("async_rst_leds",      {24'd0, leds},      32'h01);
    chk("async_rst_score_l",   {30'd0, score_l},   32'h0);
    chk("async_rst_score_r",   {30'd0, score_r},   32'h0);
    chk("async_rst_rally",     {24'd0, rally},     32'h0);
    chk("async_rst_server",    {31'd0, server},    32'h0);
    chk("async_rst_game_over", {31'd0, game_over}, 32'h0);
    repeat (2) @(negedge Clk);
    Rst = 1'b1;
    repeat (6) @(negedge Clk);
    chk("idle_after_rst_leds",  {24'd0, leds},  32'h01);
    chk("idle_after_rst_rally", {24'd0, rally}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
